// File: rtl/munky_rf_pkg.sv
// Register-file geometry and writeback source identifiers.
// Shared by the register file, decode and the writeback arbiter.
package munky_rf_pkg;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int XZR_IDX  = 31;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, the RF commit clears it.
// Queries are combinational reads of the registered mask, with no commit bypass.
module rf_scoreboard
  import munky_rf_pkg::*;
#(
  parameter int ADDR_W   = munky_rf_pkg::ADDR_W,
  parameter int NUM_REGS = munky_rf_pkg::NUM_REGS,
  parameter int XZR_IDX  = munky_rf_pkg::XZR_IDX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] q_reg1,
  input  logic [ADDR_W-1:0] q_reg2,
  output logic              q_busy1,
  output logic              q_busy2
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decoding by comparison keeps out-of-range indices from aliasing onto a real bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != XZR_IDX) begin
        set_vec[i] = set_en && (set_reg == ADDR_W'(i));
        clr_vec[i] = clr_en && (clr_reg == ADDR_W'(i));
        if (q_reg1 == ADDR_W'(i)) q_busy1 = busy[i];
        if (q_reg2 == ADDR_W'(i)) q_busy2 = busy[i];
      end
    end
  end

  // Set is applied after clear so a newer producer wins a same-edge collision.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Round-robin share of the single RF write port between ALU and load writeback,
// with a registered write stage and the busy-bit scoreboard for RAW stalls.
module rf_writeback_arbiter
  import munky_rf_pkg::*;
#(
  parameter int ADDR_W   = munky_rf_pkg::ADDR_W,
  parameter int DATA_W   = munky_rf_pkg::DATA_W,
  parameter int NUM_REGS = munky_rf_pkg::NUM_REGS,
  parameter int XZR_IDX  = munky_rf_pkg::XZR_IDX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_reg,
  input  logic [ADDR_W-1:0] q_reg1,
  input  logic [ADDR_W-1:0] q_reg2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              bad_idx
);

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic is_xzr(input logic [ADDR_W-1:0] idx);
    return int'(idx) == XZR_IDX;
  endfunction

  src_e              ptr;
  logic              both_vld;
  logic              alu_gnt;
  logic              mem_gnt;
  logic              acc_p0;
  logic [ADDR_W-1:0] acc_reg_p0;
  logic [DATA_W-1:0] acc_data_p0;

  logic              vld_p1;
  logic              bad_p1;
  logic [ADDR_W-1:0] wr_reg_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // Stage p0: grant from the valids and the pointer only, never from ready.
  always_comb begin
    both_vld    = alu_valid && mem_valid;
    alu_gnt     = alu_valid && (!mem_valid || (ptr == SRC_ALU));
    mem_gnt     = mem_valid && (!alu_valid || (ptr == SRC_MEM));
    acc_p0      = alu_gnt || mem_gnt;
    acc_reg_p0  = alu_gnt ? alu_reg  : mem_reg;
    acc_data_p0 = alu_gnt ? alu_data : mem_data;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Stage p1: registered RF write port; discarded and out-of-range writes drop RegWrite.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr        <= SRC_ALU;
      vld_p1     <= 1'b0;
      bad_p1     <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
    end else begin
      if (both_vld) begin
        ptr <= (ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
      vld_p1 <= acc_p0 && in_range(acc_reg_p0) && !is_xzr(acc_reg_p0);
      bad_p1 <= acc_p0 && !in_range(acc_reg_p0);
      if (acc_p0) begin
        wr_reg_p1  <= acc_reg_p0;
        wr_data_p1 <= acc_data_p0;
      end
    end
  end

  assign RegWrite  = vld_p1;
  assign WriteReg  = wr_reg_p1;
  assign WriteData = wr_data_p1;
  assign bad_idx   = bad_p1;

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .XZR_IDX (XZR_IDX)
  ) u_sb (
    .CLK    (CLK),
    .RESET  (RESET),
    .set_en (iss_valid),
    .set_reg(iss_reg),
    .clr_en (vld_p1),
    .clr_reg(wr_reg_p1),
    .q_reg1 (q_reg1),
    .q_reg2 (q_reg2),
    .q_busy1(q_busy1),
    .q_busy2(q_busy2)
  );

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: vector table, directed corner sequences,
// then random traffic against a behavioural model of arbitration and scoreboard.
module tb_rf_writeback_arbiter;
  import munky_rf_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        alu_valid, mem_valid, iss_valid;
  logic        alu_ready, mem_ready;
  logic [5:0]  alu_reg, mem_reg, iss_reg, q_reg1, q_reg2;
  logic [63:0] alu_data, mem_data;
  logic        q_busy1, q_busy2;
  logic [5:0]  WriteReg;
  logic [63:0] WriteData;
  logic        RegWrite, bad_idx;

  rf_writeback_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite), .bad_idx(bad_idx)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle();
    step();
    step();
    RESET = 1'b0;
  endtask

  typedef struct {
    logic        av;
    logic [5:0]  ar;
    logic [63:0] ad;
    logic        mv;
    logic [5:0]  mr;
    logic [63:0] md;
    logic        ea;
    logic        em;
    logic        erw;
    logic [5:0]  ewr;
    logic [63:0] ewd;
    logic        ebad;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(input logic av, input logic [5:0] ar, input logic [63:0] ad,
                              input logic mv, input logic [5:0] mr, input logic [63:0] md,
                              input logic ea, input logic em, input logic erw,
                              input logic [5:0] ewr, input logic [63:0] ewd, input logic ebad);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.ea = ea; v.em = em; v.erw = erw; v.ewr = ewr; v.ewd = ewd; v.ebad = ebad;
    return v;
  endfunction

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, " RegWrite"}, 64'(RegWrite), 64'(v.erw));
    chk({tag, " bad_idx"}, 64'(bad_idx), 64'(v.ebad));
    if (v.erw) begin
      chk({tag, " WriteReg"}, 64'(WriteReg), 64'(v.ewr));
      chk({tag, " WriteData"}, WriteData, v.ewd);
    end
  endtask

  // Behavioural model state for the random phase
  int          turn;
  bit          mb[32];
  bit          p_rw, p_bad;
  logic [5:0]  p_wr;
  logic [63:0] p_wd;

  initial begin
    logic one, zero;
    one = 1'b1; zero = 1'b0;
    RESET = 1'b0; idle();
    alu_reg = '0; mem_reg = '0; iss_reg = '0; q_reg1 = '0; q_reg2 = '0;
    alu_data = '0; mem_data = '0;

    vt[0] = mk(one, 6'd5,  64'hDEAD, zero, 6'd0,  64'h0,  one,  zero, one,  6'd5, 64'hDEAD, zero);
    vt[1] = mk(one, 6'd1,  64'h11,   one,  6'd2,  64'h22, one,  zero, one,  6'd1, 64'h11,   zero);
    vt[2] = mk(one, 6'd3,  64'h33,   one,  6'd2,  64'h22, zero, one,  one,  6'd2, 64'h22,   zero);
    vt[3] = mk(one, 6'd3,  64'h33,   zero, 6'd0,  64'h0,  one,  zero, one,  6'd3, 64'h33,   zero);
    vt[4] = mk(one, 6'd31, 64'h77,   zero, 6'd0,  64'h0,  one,  zero, zero, 6'd0, 64'h0,    zero);
    vt[5] = mk(zero, 6'd0, 64'h0,    one,  6'd40, 64'h55, zero, one,  zero, 6'd0, 64'h0,    one);
    vt[6] = mk(zero, 6'd0, 64'h0,    zero, 6'd0,  64'h0,  zero, zero, zero, 6'd0, 64'h0,    zero);
    vt[7] = mk(one, 6'd6,  64'h66,   one,  6'd8,  64'h88, one,  zero, one,  6'd6, 64'h66,   zero);
    vt[8] = mk(zero, 6'd0, 64'h0,    one,  6'd8,  64'h88, zero, one,  one,  6'd8, 64'h88,   zero);

    // Reset state
    do_reset();
    @(negedge CLK);
    chk("rst RegWrite", 64'(RegWrite), 64'd0);
    chk("rst WriteReg", 64'(WriteReg), 64'd0);
    chk("rst WriteData", WriteData, 64'd0);
    chk("rst bad_idx", 64'(bad_idx), 64'd0);
    chk("rst q_busy1", 64'(q_busy1), 64'd0);
    chk("rst alu_ready", 64'(alu_ready), 64'd0);
    chk("rst mem_ready", 64'(mem_ready), 64'd0);
    step();

    // Table-driven vectors, one per cycle; outputs of vector i checked during vector i+1
    for (int i = 0; i < 9; i++) begin
      alu_valid = vt[i].av; alu_reg = vt[i].ar; alu_data = vt[i].ad;
      mem_valid = vt[i].mv; mem_reg = vt[i].mr; mem_data = vt[i].md;
      @(negedge CLK);
      chk($sformatf("vec%0d alu_ready", i), 64'(alu_ready), 64'(vt[i].ea));
      chk($sformatf("vec%0d mem_ready", i), 64'(mem_ready), 64'(vt[i].em));
      if (i > 0) chk_out($sformatf("vec%0d", i - 1), vt[i - 1]);
      step();
    end
    idle();
    @(negedge CLK);
    chk_out("vec8", vt[8]);
    step();
    @(negedge CLK);
    chk("vec idle RegWrite", 64'(RegWrite), 64'd0);

    // Contended back-to-back grants after reset: ALU, MEM, ALU, MEM
    do_reset();
    alu_valid = 1'b1; alu_reg = 6'd1; alu_data = 64'hA1;
    mem_valid = 1'b1; mem_reg = 6'd2; mem_data = 64'hB2;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("rr%0d alu_ready", k), 64'(alu_ready), 64'((k % 2) == 0));
      chk($sformatf("rr%0d mem_ready", k), 64'(mem_ready), 64'((k % 2) == 1));
      if (k > 0) begin
        chk($sformatf("rr%0d RegWrite", k), 64'(RegWrite), 64'd1);
        chk($sformatf("rr%0d WriteReg", k), 64'(WriteReg), ((k - 1) % 2 == 0) ? 64'd1 : 64'd2);
      end
      step();
    end
    idle();
    @(negedge CLK);
    chk("rr4 RegWrite", 64'(RegWrite), 64'd1);
    chk("rr4 WriteReg", 64'(WriteReg), 64'd2);
    step();

    // Busy lifetime: issue 7, load writes 7, clear visible after the commit edge
    do_reset();
    q_reg1 = 6'd7; iss_valid = 1'b1; iss_reg = 6'd7;
    @(negedge CLK);
    chk("sb7 before issue", 64'(q_busy1), 64'd0);
    step();
    iss_valid = 1'b0;
    @(negedge CLK);
    chk("sb7 after issue", 64'(q_busy1), 64'd1);
    step();
    mem_valid = 1'b1; mem_reg = 6'd7; mem_data = 64'h77;
    @(negedge CLK);
    chk("sb7 mem_ready", 64'(mem_ready), 64'd1);
    chk("sb7 busy at accept", 64'(q_busy1), 64'd1);
    step();
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("sb7 RegWrite", 64'(RegWrite), 64'd1);
    chk("sb7 WriteReg", 64'(WriteReg), 64'd7);
    chk("sb7 busy during commit", 64'(q_busy1), 64'd1);
    step();
    @(negedge CLK);
    chk("sb7 cleared", 64'(q_busy1), 64'd0);
    chk("sb7 RegWrite low", 64'(RegWrite), 64'd0);
    step();

    // Issue to reg 9 on the same edge its write commits: set wins
    do_reset();
    q_reg2 = 6'd9; iss_valid = 1'b1; iss_reg = 6'd9;
    step();
    iss_valid = 1'b0; mem_valid = 1'b1; mem_reg = 6'd9; mem_data = 64'h99;
    step();
    mem_valid = 1'b0; iss_valid = 1'b1; iss_reg = 6'd9;
    @(negedge CLK);
    chk("sb9 RegWrite", 64'(RegWrite), 64'd1);
    chk("sb9 WriteReg", 64'(WriteReg), 64'd9);
    step();
    iss_valid = 1'b0; mem_valid = 1'b1; mem_reg = 6'd9; mem_data = 64'h999;
    @(negedge CLK);
    chk("sb9 set wins", 64'(q_busy2), 64'd1);
    step();
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("sb9 busy in commit", 64'(q_busy2), 64'd1);
    step();
    @(negedge CLK);
    chk("sb9 second commit clears", 64'(q_busy2), 64'd0);
    step();

    // Zero register and out-of-range: handshake completes, no write
    alu_valid = 1'b1; alu_reg = 6'd31; alu_data = 64'h1;
    iss_valid = 1'b1; iss_reg = 6'd31; q_reg1 = 6'd31; q_reg2 = 6'd40;
    @(negedge CLK);
    chk("xzr alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_reg = 6'd40; alu_data = 64'h2; iss_reg = 6'd40;
    @(negedge CLK);
    chk("xzr RegWrite", 64'(RegWrite), 64'd0);
    chk("xzr bad_idx", 64'(bad_idx), 64'd0);
    chk("xzr q_busy", 64'(q_busy1), 64'd0);
    chk("oor alu_ready", 64'(alu_ready), 64'd1);
    step();
    idle();
    @(negedge CLK);
    chk("oor RegWrite", 64'(RegWrite), 64'd0);
    chk("oor bad_idx", 64'(bad_idx), 64'd1);
    chk("oor q_busy", 64'(q_busy2), 64'd0);
    step();
    @(negedge CLK);
    chk("oor bad_idx pulse", 64'(bad_idx), 64'd0);
    step();

    // Reset in the cycle after an accept squashes the write, clears busy and pointer
    do_reset();
    alu_valid = 1'b1; alu_reg = 6'd3; alu_data = 64'h3;
    mem_valid = 1'b1; mem_reg = 6'd4; mem_data = 64'h4;
    iss_valid = 1'b1; iss_reg = 6'd12; q_reg1 = 6'd12;
    step();
    idle(); RESET = 1'b1;
    @(negedge CLK);
    chk("rst6 in-flight RegWrite", 64'(RegWrite), 64'd1);
    chk("rst6 busy before reset", 64'(q_busy1), 64'd1);
    step();
    RESET = 1'b0;
    alu_valid = 1'b1; mem_valid = 1'b1;
    @(negedge CLK);
    chk("rst6 RegWrite squashed", 64'(RegWrite), 64'd0);
    chk("rst6 busy cleared", 64'(q_busy1), 64'd0);
    chk("rst6 ptr alu_ready", 64'(alu_ready), 64'd1);
    chk("rst6 ptr mem_ready", 64'(mem_ready), 64'd0);
    step();

    // Random traffic against the behavioural model
    do_reset();
    turn = 0;
    for (int r = 0; r < 32; r++) mb[r] = 1'b0;
    p_rw = 1'b0; p_bad = 1'b0; p_wr = '0; p_wd = '0;
    begin
      bit ga, gm, a_won_prev, m_won_prev, a_first;
      logic [5:0]  w;
      logic [63:0] wd;
      a_won_prev = 1'b0; m_won_prev = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        if (!alu_valid || a_won_prev) begin
          alu_valid = ($urandom_range(0, 2) != 0);
          alu_reg   = 6'($urandom_range(0, 36));
          alu_data  = {$urandom, $urandom};
        end
        if (!mem_valid || m_won_prev) begin
          mem_valid = ($urandom_range(0, 2) != 0);
          mem_reg   = 6'($urandom_range(0, 36));
          mem_data  = {$urandom, $urandom};
        end
        iss_valid = ($urandom_range(0, 2) == 0);
        iss_reg   = 6'($urandom_range(0, 36));
        q_reg1    = 6'($urandom_range(0, 36));
        q_reg2    = 6'($urandom_range(0, 36));
        @(negedge CLK);
        // Whose turn it is only matters when both sources compete
        a_first = (turn == 0);
        ga = alu_valid && (!mem_valid || a_first);
        gm = mem_valid && (!alu_valid || !a_first);
        chk("rnd alu_ready", 64'(alu_ready), 64'(ga));
        chk("rnd mem_ready", 64'(mem_ready), 64'(gm));
        chk("rnd RegWrite", 64'(RegWrite), 64'(p_rw));
        chk("rnd bad_idx", 64'(bad_idx), 64'(p_bad));
        if (p_rw) begin
          chk("rnd WriteReg", 64'(WriteReg), 64'(p_wr));
          chk("rnd WriteData", WriteData, p_wd);
        end
        chk("rnd q_busy1", 64'(q_busy1), (q_reg1 < 6'd31) ? 64'(mb[int'(q_reg1)]) : 64'd0);
        chk("rnd q_busy2", 64'(q_busy2), (q_reg2 < 6'd31) ? 64'(mb[int'(q_reg2)]) : 64'd0);
        if (p_rw) mb[int'(p_wr)] = 1'b0;
        if (iss_valid && iss_reg < 6'd31) mb[int'(iss_reg)] = 1'b1;
        if (ga || gm) begin
          w  = ga ? alu_reg : mem_reg;
          wd = ga ? alu_data : mem_data;
          p_rw = (w < 6'd31); p_bad = (w >= 6'd32); p_wr = w; p_wd = wd;
        end else begin
          p_rw = 1'b0; p_bad = 1'b0;
        end
        if (alu_valid && mem_valid) turn = 1 - turn;
        a_won_prev = ga; m_won_prev = gm;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
